// File: rtl/fifo_write_mux.sv
// fifo_write_mux: merges NUM_CH independent push channels into one downstream
// FIFO write port. Each channel has a small circular buffer. A round-robin
// arbiter drains one word per cycle while the downstream FIFO has space.
// Optional macro FIFO_WRITE_MUX_DROP_STATS_EN adds saturating per-channel
// counters of pushes dropped because the channel buffer was full.
module fifo_write_mux #(
  parameter int NUM_CH          = 4,
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int BUF_DEPTH       = 2
) (
  input  logic                               write_clk,
  input  logic                               write_reset_n,
  input  logic [NUM_CH-1:0]                  ch_push,
  input  logic [NUM_CH*FIFO_DATA_WIDTH-1:0]  ch_data,
  output logic [NUM_CH-1:0]                  ch_full,
  output logic                               write_fifo_push,
  output logic [FIFO_DATA_WIDTH-1:0]         write_data,
  input  logic                               write_fifo_full,
  output logic [$clog2(NUM_CH)-1:0]          grant_ch,
  output logic [NUM_CH*16-1:0]               ch_drop_cnt
);

  localparam int W  = FIFO_DATA_WIDTH;
  localparam int GW = $clog2(NUM_CH);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;

  logic [NUM_CH-1:0] w_nonempty;
  logic [W-1:0]      w_head [NUM_CH];
  logic [GW-1:0]     w_sel;
  logic [GW-1:0]     w_idx;
  logic              w_found;
  logic [GW-1:0]     r_last_grant;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [W-1:0]  r_mem [BUF_DEPTH];
      logic [AW-1:0] r_wr_ptr;
      logic [AW-1:0] r_rd_ptr;
      logic [CW-1:0] r_count;
      logic          r_full;
      logic [CW-1:0] w_count_next;
      logic          w_push_ok;
      logic          w_pop;

      // A push is admitted only if the registered full flag was low when sampled.
      assign w_push_ok = ch_push[gi] & ~r_full;
      assign w_pop     = write_fifo_push & (w_sel == GW'(gi));

      // Occupancy after this edge; push and pop together leave it unchanged.
      always_comb begin
        w_count_next = r_count + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_pop};
      end

      // Pointer, count and full-flag state; pointers wrap naturally (power-of-two depth).
      always_ff @(posedge write_clk) begin
        if (!write_reset_n) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
          r_full   <= 1'b0;
        end else begin
          if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
          if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
          r_count <= w_count_next;
          r_full  <= (w_count_next == CW'(BUF_DEPTH));
        end
      end

      // Buffer storage; no reset needed since the count qualifies every entry.
      always_ff @(posedge write_clk) begin
        if (write_reset_n && w_push_ok) r_mem[r_wr_ptr] <= ch_data[gi*W +: W];
      end

      assign w_nonempty[gi] = (r_count != '0);
      assign w_head[gi]     = r_mem[r_rd_ptr];
      assign ch_full[gi]    = r_full;

`ifdef FIFO_WRITE_MUX_DROP_STATS_EN
      logic [15:0] r_drop_cnt;
      // Count pushes rejected by a full buffer, saturating at all-ones.
      always_ff @(posedge write_clk) begin
        if (!write_reset_n) begin
          r_drop_cnt <= '0;
        end else if (ch_push[gi] && r_full && (r_drop_cnt != 16'hFFFF)) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end
      assign ch_drop_cnt[gi*16 +: 16] = r_drop_cnt;
`else
      assign ch_drop_cnt[gi*16 +: 16] = 16'h0000;
`endif
    end
  endgenerate

  // Round-robin search: first non-empty channel starting after the last grant.
  always_comb begin
    w_sel   = r_last_grant;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_idx = GW'((int'(r_last_grant) + i) % NUM_CH);
      if (!w_found && w_nonempty[w_idx]) begin
        w_sel   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign write_fifo_push = (|w_nonempty) & ~write_fifo_full;
  assign grant_ch        = write_fifo_push ? w_sel : r_last_grant;
  assign write_data      = write_fifo_push ? w_head[w_sel] : '0;

  // Remember the winner only on edges where a word actually leaves.
  always_ff @(posedge write_clk) begin
    if (!write_reset_n) begin
      r_last_grant <= GW'(NUM_CH - 1);
    end else if (write_fifo_push) begin
      r_last_grant <= w_sel;
    end
  end

endmodule

// File: doc/fifo_write_mux.md
FIFO_WRITE_MUX -- requirements
Module: fifo_write_mux

Interface
REQ-001 Parameter: NUM_CH, default 4, number of independent write channels (2..16).
REQ-002 Parameter: FIFO_DATA_WIDTH, default 32, data width of every channel and of the merged output.
REQ-003 Parameter: BUF_DEPTH, default 2, entries per channel buffer (power of two, >=2).
REQ-004 Port: write_clk  input  1  single clock for all logic.
REQ-005 Port: write_reset_n  input  1  reset; one clock, reset synchronous and active-low.
REQ-006 Port: ch_push  input  NUM_CH  per-channel push strobe.
REQ-007 Port: ch_data  input  NUM_CH*FIFO_DATA_WIDTH  per-channel data; channel k occupies bits [k*W +: W].
REQ-008 Port: ch_full  output  NUM_CH  per-channel buffer full, registered.
REQ-009 Port: write_fifo_push  output  1  push to downstream FIFO write port.
REQ-010 Port: write_data  output  FIFO_DATA_WIDTH  data to downstream FIFO.
REQ-011 Port: write_fifo_full  input  1  downstream FIFO full.
REQ-012 Port: grant_ch  output  $clog2(NUM_CH)  channel index sourcing current write_data.
REQ-013 Port: ch_drop_cnt  output  NUM_CH*16  per-channel dropped-push counters (see Configuration).

Function
REQ-014 Each channel SHALL own a BUF_DEPTH-entry circular buffer with wrapping read/write pointers and a count register.
REQ-015 ch_push[k] with ch_full[k] low SHALL write ch_data[k] into buffer k at the rising edge.
REQ-016 ch_push[k] with ch_full[k] high SHALL be dropped; buffer contents and pointers unchanged.
REQ-017 ch_full[k] SHALL be registered: high exactly when count[k]==BUF_DEPTH after the edge; a pop in the same cycle does not admit a push sampled while ch_full[k] was high.
REQ-018 write_fifo_push SHALL be combinational: high when any buffer is non-empty and write_fifo_full is low.
REQ-019 Arbitration SHALL be round-robin: first non-empty channel searched from (last_grant+1) mod NUM_CH upward, wrapping.
REQ-020 write_data and grant_ch SHALL present the head entry of the selected channel whenever write_fifo_push is high; grant_ch holds last_grant otherwise, write_data undefined-safe (driven 0).
REQ-021 A pop from the granted buffer and an update of last_grant SHALL occur only on edges where write_fifo_push is high.
REQ-022 Simultaneous push and pop on one channel SHALL leave count unchanged and preserve FIFO order.
REQ-023 Minimum latency: a word pushed into an empty buffer SHALL be eligible for output in the next cycle.
REQ-024 Per-channel ordering SHALL be preserved; no word is duplicated or lost except per REQ-016.
REQ-025 With write_fifo_full high, no pop occurs and last_grant holds.

Reset
REQ-026 On a write_clk edge with write_reset_n low: all counts and pointers 0, ch_full all 0, last_grant NUM_CH-1 (channel 0 wins first), ch_drop_cnt all 0.
REQ-027 Reset mid-operation SHALL discard all buffered data; write_fifo_push low in the cycle after reset is sampled, grant_ch reads NUM_CH-1.
REQ-028 Pushes sampled while write_reset_n is low SHALL be ignored and not counted.

Configuration
REQ-029 Macro FIFO_WRITE_MUX_DROP_STATS_EN defined: ch_drop_cnt[k] SHALL increment by 1 on every dropped push on channel k, saturating at 16'hFFFF.
REQ-030 Macro undefined: ch_drop_cnt SHALL be tied to all zeros and no counter flops instantiated; all other behaviour identical.

Verification
REQ-031 Reset release, channels 0 and 2 push 0xA0/0xC0 same cycle, write_fifo_full=0 -> outputs 0xA0 (grant 0) then 0xC0 (grant 2) on consecutive cycles.
REQ-032 All 4 channels hold data continuously, downstream never full -> grant_ch sequence 0,1,2,3,0,1..., one push per cycle.
REQ-033 write_fifo_full=1, channel 1 pushes 3 words (BUF_DEPTH=2) -> ch_full[1] high after 2nd, 3rd dropped, ch_drop_cnt[1]=1 with macro, 0 without; release full -> exactly 2 words out in order.
REQ-034 Channel 3 buffer full, push and downstream pop same cycle -> push dropped per REQ-017; next cycle push accepted, order preserved.
REQ-035 Reset asserted with 2 words buffered in each channel -> next cycle write_fifo_push=0, ch_full=0, no stale data emitted after release.
REQ-036 Macro defined, 70000 dropped pushes on channel 0 -> ch_drop_cnt[0] saturates at 0xFFFF.
